// File: rtl/bl_order_decode_pkg.sv
// Shared X-engine constants and elaboration-time helpers for the baseline order decoder.
package bl_order_decode_pkg;

  // Antenna index width for an antenna count that is a power of two.
  function automatic int unsigned ant_bits_f(input int unsigned n);
    return unsigned'($clog2(n));
  endfunction

  // Width of the canonical triangular baseline index, autocorrelations included.
  function automatic int unsigned bl_bits_f(input int unsigned n);
    return unsigned'($clog2(n * (n + 1) / 2));
  endfunction

  // Samples per frame in generator order: N rows of N/2+1 pairs.
  function automatic int unsigned frame_len_f(input int unsigned n);
    return n * (n / 2 + 1);
  endfunction

  // Triangular number h*(h+1)/2, the row base of antenna h.
  function automatic int unsigned tri_num_f(input int unsigned h);
    return h * (h + 1) / 2;
  endfunction

  localparam int unsigned DefaultNAnts = 16;
  localparam int unsigned FrameLen     = frame_len_f(DefaultNAnts);

endpackage

// File: rtl/bl_tri_lut.sv
// Combinational ROM mapping antenna index hi to hi*(hi+1)/2, filled at elaboration.
module bl_tri_lut
  import bl_order_decode_pkg::*;
#(
  parameter  int unsigned N_ANTS   = 16,
  localparam int unsigned ANT_BITS = ant_bits_f(N_ANTS),
  localparam int unsigned BL_BITS  = bl_bits_f(N_ANTS)
) (
  input  logic [ANT_BITS-1:0] hi,
  output logic [BL_BITS-1:0]  tri_val
);

  logic [BL_BITS-1:0] rom [N_ANTS];

  for (genvar i = 0; i < N_ANTS; i++) begin : g_rom
    assign rom[i] = BL_BITS'(tri_num_f(i));
  end

  assign tri_val = rom[hi];

endmodule

// File: rtl/bl_order_decode.sv
// Tags correlator samples arriving in X-engine generator order with their canonical baseline.
// Two register stages: stage 1 resolves the pair and looks up tri(hi), stage 2 adds lo.
// Optional build macro BL_ORDER_DECODE_DUP_DROP_EN drops the duplicate a-b==N/2 samples.
module bl_order_decode
  import bl_order_decode_pkg::*;
#(
  parameter  int unsigned N_ANTS     = 16,
  parameter  int unsigned DATA_WIDTH = 36,
  localparam int unsigned ANT_BITS   = ant_bits_f(N_ANTS),
  localparam int unsigned BL_BITS    = bl_bits_f(N_ANTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sync,
  input  logic                  din_valid,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  dout_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ANT_BITS-1:0]   ant_lo,
  output logic [ANT_BITS-1:0]   ant_hi,
  output logic [BL_BITS-1:0]    bl_idx,
  output logic                  conj,
  output logic                  dup,
  output logic                  frame_buf,
  output logic                  frame_last,
  output logic                  sync_out
);

  localparam logic [ANT_BITS-1:0] One    = ANT_BITS'(1);
  localparam logic [ANT_BITS-1:0] Half   = ANT_BITS'(N_ANTS / 2);
  localparam logic [ANT_BITS-1:0] AntMax = ANT_BITS'(N_ANTS - 1);

  // Generator-order tracking state
  logic [ANT_BITS-1:0] a_q, b_q, off_q;
  logic                parity_q;
  logic                row_start_q;  // current (a,b) is the first pair of its row

  // Stage 1 registers
  logic                  s1_valid, s1_conj, s1_dup, s1_buf, s1_last;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [ANT_BITS-1:0]   s1_lo, s1_hi;
  logic [BL_BITS-1:0]    s1_tri;

  logic                sync_d1;
  logic                accept, emit, conj_c, dup_c, last_c;
  logic [ANT_BITS-1:0] lo_c, hi_c;
  logic [BL_BITS-1:0]  tri_c;

  // A sample coinciding with sync is discarded.
  assign accept = din_valid & ~sync;

  // Canonical pair for the current generator position.
  always_comb begin
    conj_c = (a_q > b_q);
    lo_c   = conj_c ? b_q : a_q;
    hi_c   = conj_c ? a_q : b_q;
    // First pair of a row b>=N/2 is (b-N/2, b), already produced by row b-N/2.
    dup_c  = row_start_q & b_q[ANT_BITS-1] & (a_q == b_q - Half);
    last_c = (a_q == AntMax) & (b_q == AntMax);
  end

  bl_tri_lut #(
    .N_ANTS (N_ANTS)
  ) u_tri_lut (
    .hi      (hi_c),
    .tri_val (tri_c)
  );

`ifdef BL_ORDER_DECODE_DUP_DROP_EN
  assign emit = s1_valid & ~s1_dup;
`else
  assign emit = s1_valid;
`endif

  // Advance the generator mirror on each accepted sample; sync restarts the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      off_q       <= '0;
      parity_q    <= 1'b0;
      row_start_q <= 1'b0;
    end else if (sync) begin
      b_q         <= '0;
      a_q         <= Half;
      off_q       <= Half + One;
      parity_q    <= 1'b0;
      row_start_q <= 1'b1;
    end else if (din_valid) begin
      if (a_q == b_q) begin
        b_q         <= b_q + One;
        a_q         <= off_q;
        off_q       <= off_q + One;
        row_start_q <= 1'b1;
      end else begin
        a_q         <= a_q + One;
        row_start_q <= 1'b0;
      end
      if (last_c) parity_q <= ~parity_q;
    end
  end

  // Stage 1: capture sample with its resolved pair, flags and tri(hi).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_lo    <= '0;
      s1_hi    <= '0;
      s1_tri   <= '0;
      s1_conj  <= 1'b0;
      s1_dup   <= 1'b0;
      s1_buf   <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= din;
        s1_lo   <= lo_c;
        s1_hi   <= hi_c;
        s1_tri  <= tri_c;
        s1_conj <= conj_c;
        s1_dup  <= dup_c;
        s1_buf  <= parity_q;
        s1_last <= last_c;
      end
    end
  end

  // Stage 2: form the triangular index; sideband holds across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
      dout       <= '0;
      ant_lo     <= '0;
      ant_hi     <= '0;
      bl_idx     <= '0;
      conj       <= 1'b0;
      dup        <= 1'b0;
      frame_buf  <= 1'b0;
      frame_last <= 1'b0;
    end else begin
      dout_valid <= emit;
      if (emit) begin
        dout       <= s1_data;
        ant_lo     <= s1_lo;
        ant_hi     <= s1_hi;
        bl_idx     <= s1_tri + BL_BITS'(s1_lo);
        conj       <= s1_conj;
        dup        <= s1_dup;
        frame_buf  <= s1_buf;
        frame_last <= s1_last;
      end
    end
  end

  // Delay sync by the pipeline depth, regardless of sample traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_d1  <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      sync_d1  <= sync;
      sync_out <= sync_d1;
    end
  end

endmodule

// File: tb/tb_bl_order_decode.sv
// Self-checking bench for bl_order_decode (N_ANTS=16, DATA_WIDTH=36).
module tb_bl_order_decode;

  localparam int N     = 16;
  localparam int H     = N / 2;
  localparam int DW    = 36;
  localparam int FRAME = N * (H + 1);
  localparam int NBL   = N * (N + 1) / 2;
`ifdef BL_ORDER_DECODE_DUP_DROP_EN
  localparam bit DROP     = 1'b1;
  localparam int ND       = H;   // dropped per frame
  localparam int EXP_DUPS = 0;
`else
  localparam bit DROP     = 1'b0;
  localparam int ND       = 0;
  localparam int EXP_DUPS = H;
`endif

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
    logic [3:0]    lo;
    logic [3:0]    hi;
    logic [7:0]    idx;
    logic          conj;
    logic          dup;
    logic          fbuf;
    logic          last;
  } tag_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          sync = 1'b0;
  logic          din_valid = 1'b0;
  logic [DW-1:0] din = '0;
  logic          dout_valid, conj, dup, frame_buf, frame_last, sync_out;
  logic [DW-1:0] dout;
  logic [3:0]    ant_lo, ant_hi;
  logic [7:0]    bl_idx;

  bl_order_decode #(
    .N_ANTS     (N),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sync       (sync),
    .din_valid  (din_valid),
    .din        (din),
    .dout_valid (dout_valid),
    .dout       (dout),
    .ant_lo     (ant_lo),
    .ant_hi     (ant_hi),
    .bl_idx     (bl_idx),
    .conj       (conj),
    .dup        (dup),
    .frame_buf  (frame_buf),
    .frame_last (frame_last),
    .sync_out   (sync_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Baseline of the k-th sample of a frame, from row/position arithmetic.
  function automatic tag_t model_tag(input int k, input bit par, input logic [DW-1:0] d);
    tag_t t;
    int row, pos, a, b, lo, hi;
    row    = k / (H + 1);
    pos    = k % (H + 1);
    b      = row;
    a      = (row + H + pos) % N;
    lo     = (a < b) ? a : b;
    hi     = (a < b) ? b : a;
    t.d    = d;
    t.lo   = 4'(lo);
    t.hi   = 4'(hi);
    t.idx  = 8'(hi * (hi + 1) / 2 + lo);
    t.conj = (a > b);
    t.dup  = (b >= H) && (pos == 0);
    t.fbuf = par;
    t.last = (k == FRAME - 1);
    t.v    = !(DROP && t.dup);
    return t;
  endfunction

  // Model: frame position counter plus a two-deep delay line.
  int   mk = 0;
  bit   mpar = 1'b0;
  tag_t e1 = '0;
  tag_t held = '0;
  logic exp_valid = 1'b0;
  logic s1 = 1'b0, s2 = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mk <= 0; mpar <= 1'b0; e1 <= '0; held <= '0; exp_valid <= 1'b0; s1 <= 1'b0; s2 <= 1'b0;
    end else begin
      s1 <= sync;
      s2 <= s1;
      exp_valid <= e1.v;
      if (e1.v) held <= e1;
      if (sync) begin
        e1 <= '0; mk <= 0; mpar <= 1'b0;
      end else if (din_valid) begin
        e1 <= model_tag(mk, mpar, din);
        if (mk == FRAME - 1) begin
          mk <= 0; mpar <= ~mpar;
        end else begin
          mk <= mk + 1;
        end
      end else begin
        e1 <= '0;
      end
    end
  end

  tag_t outq[$];
  tag_t act_t;

  // Per-cycle comparison against the model; log every emitted sample.
  always @(negedge clk) begin
    act_t = '{v: dout_valid, d: dout, lo: ant_lo, hi: ant_hi, idx: bl_idx, conj: conj,
              dup: dup, fbuf: frame_buf, last: frame_last};
    check("outputs", 64'(act_t), 64'({exp_valid, held.d, held.lo, held.hi, held.idx,
                                      held.conj, held.dup, held.fbuf, held.last}));
    check("sync_out", 64'(sync_out), 64'(s2));
    if (dout_valid) outq.push_back(act_t);
  end

  task automatic step(input bit s, input bit v, input logic [DW-1:0] d);
    sync = s; din_valid = v; din = d;
    @(negedge clk);
  endtask

  function automatic logic [19:0] tagbits(input tag_t t);
    return {t.lo, t.hi, t.idx, t.conj, t.dup, t.fbuf, t.last};
  endfunction

  tag_t ref_q[$];
  int   base, cnt, nd, missing, sent;
  int   seen[NBL];
  tag_t t;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", 64'(dout_valid), 64'd0);
    check("reset_idx", 64'(bl_idx), 64'd0);
    rst_n = 1'b1;
    step(0, 0, '0); step(0, 0, '0);

    // Contiguous frame plus the start of the next one.
    base = outq.size();
    step(1, 0, '0);
    for (int i = 0; i < FRAME + 10; i++) step(0, 1, DW'(i));
    repeat (4) step(0, 0, '0);
    t = outq[base];
    check("first_pair", 64'({t.lo, t.hi, t.conj, t.idx}), 64'({4'd0, 4'd8, 1'b1, 8'd36}));
    t = outq[base + 8];
    check("auto_0_0", 64'({t.idx, t.conj, t.d}), 64'({8'd0, 1'b0, 36'd8}));
    t = outq[base + FRAME - 1 - ND];
    check("frame_last", 64'({t.lo, t.hi, t.idx, t.last}), 64'({4'd15, 4'd15, 8'd135, 1'b1}));
    t = outq[base + FRAME - ND];
    check("next_frame", 64'({t.fbuf, t.idx, t.last}), 64'({1'b1, 8'd36, 1'b0}));
`ifndef BL_ORDER_DECODE_DUP_DROP_EN
    t = outq[base + 72];
    check("row8_dup", 64'({t.lo, t.hi, t.dup, t.idx}), 64'({4'd0, 4'd8, 1'b1, 8'd36}));
`endif
    cnt = 0; nd = 0; missing = 0;
    for (int i = 0; i < NBL; i++) seen[i] = 0;
    for (int i = base; i < outq.size(); i++) begin
      if (outq[i].fbuf == 1'b0) begin
        cnt++;
        if (outq[i].dup) nd++;
        if (int'(outq[i].idx) < NBL) seen[outq[i].idx]++;
        ref_q.push_back(outq[i]);
      end
    end
    for (int i = 0; i < NBL; i++) if (seen[i] == 0) missing++;
    check("frame_count", 64'(cnt), 64'(FRAME - ND));
    check("dup_count", 64'(nd), 64'(EXP_DUPS));
    check("idx_missing", 64'(missing), 64'd0);

    // Same frame with random bubbles: identical tag sequence.
    base = outq.size();
    step(1, 0, '0);
    sent = 0;
    for (int it = 0; it < 4000 && sent < FRAME; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        step(0, 1, DW'(sent + 1000));
        sent++;
      end else begin
        step(0, 0, '0);
      end
    end
    repeat (4) step(0, 0, '0);
    check("gap_count", 64'(outq.size() - base), 64'(FRAME - ND));
    for (int i = 0; i < FRAME - ND && i < ref_q.size(); i++)
      check("gap_tags", 64'(tagbits(outq[base + i])), 64'(tagbits(ref_q[i])));

    // Sync with din_valid at sample 70: in-flight samples drain, frame restarts.
    base = outq.size();
    step(1, 0, '0);
    for (int i = 0; i < 70; i++) step(0, 1, DW'(i));
    step(1, 1, DW'(999));
    for (int i = 0; i < 5; i++) step(0, 1, DW'(i + 500));
    repeat (4) step(0, 0, '0);
    check("resync_count", 64'(outq.size() - base), 64'd75);
    t = outq[base + 68];
    check("inflight_68", 64'({t.lo, t.hi, t.idx}), 64'({4'd4, 4'd7, 8'd32}));
    t = outq[base + 69];
    check("inflight_69", 64'({t.lo, t.hi, t.idx, t.d}), 64'({4'd5, 4'd7, 8'd33, 36'd69}));
    t = outq[base + 70];
    check("resync_first", 64'({t.lo, t.hi, t.idx, t.fbuf, t.d}),
          64'({4'd0, 4'd8, 8'd36, 1'b0, 36'd500}));

    // Asynchronous reset mid-stream clears outputs at once.
    step(1, 0, '0);
    for (int i = 0; i < 20; i++) step(0, 1, DW'(i));
    #2 rst_n = 1'b0;
    din_valid = 1'b0;
    #1;
    check("async_reset", 64'({dout_valid, dout, ant_lo, ant_hi, bl_idx, conj, dup, frame_buf,
                              frame_last, sync_out}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, '0);
    base = outq.size();
    step(1, 0, '0);
    step(0, 1, DW'(5));
    step(0, 1, DW'(6));
    repeat (4) step(0, 0, '0);
    t = outq[base];
    check("post_reset_first", 64'({t.lo, t.hi, t.conj, t.idx, t.d}),
          64'({4'd0, 4'd8, 1'b1, 8'd36, 36'd5}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
